rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between three writeback sources:
//  ALU result (req 0), memory load (req 1) and stack unit SP update (req 2).
//  Sits between execute/memory/stack stages and the register file write port.
//  - Arbitrates with round-robin and a one-entry registered output stage.
//  - Supports a hold (backpressure) input and exports a pending-write scoreboard
//    so decode can stall reads of registers with in-flight writes.
// PARAMETERS
//  DATA_W  8  register data width
//  ADDR_W  2  register address width (R3 = SP)
//  CNT_W   8  width of saturating contention counter
// PORTS
//  clk           in   1             system clock, all state on rising edge
//  rst           in   1             asynchronous, active-high reset
//  req_valid     in   3             per-requester write request ([0]=ALU,[1]=MEM,[2]=STACK)
//  req_ready     out  3             per-requester grant; transfer when valid&ready
//  req_addr      in   3*ADDR_W      packed target addresses, req i at [i*ADDR_W +: ADDR_W]
//  req_data      in   3*DATA_W      packed write data, req i at [i*DATA_W +: DATA_W]
//  hold          in   1             freeze register file writes this cycle
//  wr_en         out  1             register file write enable
//  wr_addr       out  ADDR_W        register file write address
//  wr_data       out  DATA_W        register file write data
//  pending       out  2**ADDR_W     bit n set = write to Rn staged, not yet committed
//  contention    out  CNT_W         saturating count of cycles with >=2 valid requests
// BEHAVIOUR
//  - Reset (async, rst=1): stage empty, wr_en=0, wr_addr=0, wr_data=0, pending=0,
//    contention=0, req_ready=0, last-grant pointer=2 (so req 0 is first priority).
//  - Stage regs: stg_valid, stg_addr, stg_data. wr_en = stg_valid & ~hold (comb);
//    wr_addr/wr_data = stg_addr/stg_data.
//  - can_load = ~stg_valid | ~hold. Stage loads on rising edge when can_load.
//  - Arbitration (comb): search order starts at (last+1) mod 3, wraps; first valid
//    requester wins. req_ready = one-hot winner & can_load; all 0 if none valid.
//  - On transfer: stage <= winner addr/data, stg_valid<=1, last<=winner index.
//  - can_load with no transfer: stg_valid<=0 (staged write committed this cycle).
//  - hold=1 with stg_valid=1: stage retained, wr_en=0, req_ready=0, pointer unchanged.
//  - Latency: accept in cycle N -> wr_en=1 in cycle N+1 (no hold). Throughput 1/cycle.
//  - pending = decode(stg_addr) when stg_valid, else 0.
//  - contention += 1 each cycle with >=2 bits of req_valid set, including under
//    hold; saturates at all-ones, no wrap.
//  - Duplicate addresses from different requesters are not merged; each is
//    committed in grant order, last grant wins in the register file.
//  - Requester must hold valid/addr/data stable until ready; a dropped valid
//    forfeits without affecting the pointer.
//  - Reset mid-operation: staged write is discarded, wr_en falls immediately.
// CONFIGURATION
//  RF_ARB_SP_PRIORITY_EN
//   - defined: req 2 (STACK) wins whenever valid; round-robin among req 0/1 only,
//     pointer not updated on stack grants; stack can starve ALU/MEM.
//   - undefined: plain 3-way round-robin as above; max wait 2 grants.
// TESTING
//  1 rst=1 with req_valid=3'b111 -> wr_en=0, req_ready=0, pending=0, contention=0.
//  2 Only req0 addr=1 data=BB -> req_ready=001 same cycle; next cycle wr_en=1,
//    wr_addr=1, wr_data=BB, pending=0010.
//  3 All valid (A0 0x11, A1 0x22, A3 0xFE) held 4 cycles -> grants 0,1,2,0;
//    writes R0,R1,R3,R0 on following cycles; contention=4.
//  4 Stage holds R2=0xCC, hold=1 for 3 cycles -> wr_en=0, req_ready=000,
//    pending=0100; hold=0 -> wr_en=1 addr 2 data CC same cycle.
//  5 Stage valid, rst pulsed mid-cycle -> wr_en=0 and pending=0 without clock edge;
//    after release req0 is first granted.
//  6 RF_ARB_SP_PRIORITY_EN defined, all valid 3 cycles -> req_ready=100 each cycle;
//    undefined -> 001,010,100.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register file write port, one-entry output stage.
// Optional RF_ARB_SP_PRIORITY_EN: stack requester (req 2) takes strict priority over ALU/MEM.
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req_valid,
  output logic [2:0]              req_ready,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_data,
  input  logic                    hold,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [(2**ADDR_W)-1:0]  pending,
  output logic [CNT_W-1:0]        contention
);

  logic              stg_valid;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;
  logic [1:0]        last;
  logic              can_load;
  logic              any_valid;
  logic              multi_valid;
  logic [1:0]        win;
  logic [2:0]        grant;
  logic [1:0]        p0, p1, p2;

  assign can_load    = ~stg_valid | ~hold;
  assign any_valid   = |req_valid;
  assign multi_valid = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

  // Search order begins just after the last granted requester.
  always_comb begin
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
  end

  always_comb begin
    win = 2'd0;
`ifdef RF_ARB_SP_PRIORITY_EN
    if (req_valid[2])    win = 2'd2;
    else if (last == 2'd0) win = req_valid[1] ? 2'd1 : 2'd0;
    else                 win = req_valid[0] ? 2'd0 : 2'd1;
`else
    if (req_valid[p0])      win = p0;
    else if (req_valid[p1]) win = p1;
    else                    win = p2;
`endif
    grant = any_valid ? (3'b001 << win) : 3'b000;
  end

  // Outputs are forced quiet while reset is asserted, even though the stage is empty.
  assign req_ready = grant & {3{can_load & ~rst}};
  assign wr_en     = stg_valid & ~hold;
  assign wr_addr   = stg_addr;
  assign wr_data   = stg_data;

  always_comb begin
    pending = '0;
    if (stg_valid) pending[stg_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      last      <= 2'd2;
    end else if (can_load) begin
      if (any_valid) begin
        stg_valid <= 1'b1;
        stg_addr  <= req_addr[win*ADDR_W +: ADDR_W];
        stg_data  <= req_data[win*DATA_W +: DATA_W];
`ifdef RF_ARB_SP_PRIORITY_EN
        if (win != 2'd2) last <= win;
`else
        last <= win;
`endif
      end else begin
        stg_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention <= '0;
    end else if (multi_valid && (contention != {CNT_W{1'b1}})) begin
      contention <= contention + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter.
`timescale 1ns/1ps
module tb_rf_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_valid;
  logic [2:0] req_ready;
  logic [5:0] req_addr;
  logic [23:0] req_data;
  logic       hold;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pending;
  logic [7:0] contention;

  int n_pass = 0;
  int n_total = 0;

  logic [9:0] sb[$];
  int         m_last = 2;
  bit         m_stg = 1'b0;
  bit         m_can;
  int         m_w;
  logic [2:0] m_ready;
  logic [9:0] m_exp;

  rf_write_arbiter #(.DATA_W(8), .ADDR_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .contention(contention)
  );

  always #10 clk = ~clk;

  function automatic int model_winner(input logic [2:0] v, input int last);
`ifdef RF_ARB_SP_PRIORITY_EN
    if (v[2]) return 2;
    if (last == 0) begin
      if (v[1]) return 1;
      if (v[0]) return 0;
    end else begin
      if (v[0]) return 0;
      if (v[1]) return 1;
    end
    return -1;
`else
    for (int k = 1; k <= 3; k++)
      if (v[(last + k) % 3]) return (last + k) % 3;
    return -1;
`endif
  endfunction

  // Reference model: checks grants and write enable each cycle, scoreboards staged writes.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_last = 2;
      m_stg  = 1'b0;
      sb.delete();
    end else begin
      m_can   = !m_stg || !hold;
      m_w     = model_winner(req_valid, m_last);
      m_ready = (m_can && m_w >= 0) ? 3'(1 << m_w) : 3'b000;
      n_total++;
      if (req_ready !== m_ready) $display("FAIL grant: req_ready=%b expected %b", req_ready, m_ready);
      else n_pass++;
      n_total++;
      if (wr_en !== (m_stg && !hold)) $display("FAIL wr_en: got %b expected %b", wr_en, m_stg && !hold);
      else n_pass++;
      if (wr_en === 1'b1) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL commit: unexpected write addr=%0d data=%h", wr_addr, wr_data);
        end else begin
          m_exp = sb.pop_front();
          if ({wr_addr, wr_data} !== m_exp)
            $display("FAIL commit: addr/data=%0d/%h expected %0d/%h", wr_addr, wr_data, m_exp[9:8], m_exp[7:0]);
          else n_pass++;
        end
      end
      if (m_ready != 3'b000) begin
        sb.push_back({req_addr[m_w*2 +: 2], req_data[m_w*8 +: 8]});
        m_stg = 1'b1;
`ifdef RF_ARB_SP_PRIORITY_EN
        if (m_w != 2) m_last = m_w;
`else
        m_last = m_w;
`endif
      end else if (m_can) begin
        m_stg = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 3'b000; hold = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_addr = 6'b11_01_00; req_data = 24'hFE_22_11;
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b expected 000", req_ready); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b expected 0000", pending); else n_pass++;
    n_total++; if (contention !== 8'd0) $display("FAIL reset_contention: got %0d expected 0", contention); else n_pass++;
    n_total++; if ({wr_addr, wr_data} !== 10'd0) $display("FAIL reset_wr_bus: got %h expected 0", {wr_addr, wr_data}); else n_pass++;
    repeat (2) @(posedge clk);
    #1 req_valid = 3'b000; rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b001; req_addr = 6'b00_00_01; req_data = 24'h00_00_BB;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL single_ready: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = 3'b000;
    #1;
    n_total++; if (wr_en !== 1'b1) $display("FAIL single_wr_en: got %b expected 1", wr_en); else n_pass++;
    n_total++; if (wr_addr !== 2'd1) $display("FAIL single_addr: got %0d expected 1", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 8'hBB) $display("FAIL single_data: got %h expected BB", wr_data); else n_pass++;
    n_total++; if (pending !== 4'b0010) $display("FAIL single_pending: got %b expected 0010", pending); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready[4];
    logic [1:0] exp_addr[4];
`ifdef RF_ARB_SP_PRIORITY_EN
    exp_ready = '{3'b100, 3'b100, 3'b100, 3'b100};
    exp_addr  = '{2'd3, 2'd3, 2'd3, 2'd3};
`else
    exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr  = '{2'd0, 2'd1, 2'd3, 2'd0};
`endif
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b111; req_addr = 6'b11_01_00; req_data = 24'hFE_22_11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (req_ready !== exp_ready[i]) $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_ready[i]);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== exp_addr[i-1])
          $display("FAIL rr_write%0d: wr_en=%b addr=%0d expected 1/%0d", i, wr_en, wr_addr, exp_addr[i-1]);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    req_valid = 3'b000;
    #1;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== exp_addr[3])
      $display("FAIL rr_write3: wr_en=%b addr=%0d expected 1/%0d", wr_en, wr_addr, exp_addr[3]);
    else n_pass++;
    n_total++; if (contention !== 8'd4) $display("FAIL rr_contention: got %0d expected 4", contention); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b010; req_addr = 6'b00_10_00; req_data = 24'h00_CC_33;
    @(posedge clk); #1;
    hold = 1'b1; req_valid = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (wr_en !== 1'b0) $display("FAIL hold_wr_en%0d: got %b expected 0", i, wr_en); else n_pass++;
      n_total++; if (req_ready !== 3'b000) $display("FAIL hold_ready%0d: got %b expected 000", i, req_ready); else n_pass++;
      n_total++; if (pending !== 4'b0100) $display("FAIL hold_pending%0d: got %b expected 0100", i, pending); else n_pass++;
      @(posedge clk); #1;
    end
    hold = 1'b0;
    #1;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd2 || wr_data !== 8'hCC)
      $display("FAIL hold_release: wr_en=%b addr=%0d data=%h expected 1/2/CC", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_total++; if (req_ready !== 3'b001) $display("FAIL hold_release_ready: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = 3'b000;
    #1;
    n_total++; if (pending !== 4'b0001) $display("FAIL hold_next_pending: got %b expected 0001", pending); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b001; req_addr = 6'b00_01_11; req_data = 24'h00_77_5A;
    @(posedge clk); #1;
    req_valid = 3'b011;
    #1;
    n_total++; if (pending !== 4'b1000) $display("FAIL mid_pending_before: got %b expected 1000", pending); else n_pass++;
    n_total++; if (req_ready !== 3'b010) $display("FAIL mid_ready_before: got %b expected 010", req_ready); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b expected 0", wr_en); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL mid_pending: got %b expected 0000", pending); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL mid_ready_in_reset: got %b expected 000", req_ready); else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL mid_ready_after: got %b expected 001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = 3'b000;
  endtask

  task automatic test_saturation();
    do_reset();
    @(posedge clk); #1;
    req_valid = 3'b111; req_addr = 6'b10_01_00; req_data = 24'h33_22_11;
    repeat (100) @(posedge clk);
    #2;
    n_total++; if (contention !== 8'd100) $display("FAIL sat_mid: got %0d expected 100", contention); else n_pass++;
    repeat (160) @(posedge clk);
    #1 req_valid = 3'b000;
    @(posedge clk); #2;
    n_total++; if (contention !== 8'd255) $display("FAIL sat_end: got %0d expected 255", contention); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_saturation();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
